// File: rtl/raw_hits_readout_pkg.sv
// Shared constants and types for the raw-hit L1A readout block.
package raw_hits_readout_pkg;

   localparam int unsigned NWIRES    = 672;
   localparam int unsigned WORD_W    = 16;
   localparam int unsigned BIN_AW    = 5;
   localparam int unsigned NWORDS    = NWIRES / WORD_W;
   localparam int unsigned WORD_AW   = $clog2(NWORDS);
   localparam int unsigned RAM_DEPTH = 2 ** BIN_AW;
   localparam int unsigned L1A_CNT_W = 12;

   // Marker nibble in the top of every event header word.
   localparam logic [3:0] HDR_MARK = 4'hD;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_HEADER  = 2'd2,
      ST_SEND    = 2'd3
   } state_t;

endpackage

// File: rtl/raw_hits_readout_ram.sv
// Simple dual-port frame memory, one raw-hit frame per bin, registered read.
// A same-address write is forwarded to the read register (write-first), so a
// frame captured on an edge is readable on the very next cycle.
module raw_frame_ram
   import raw_hits_readout_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [BIN_AW-1:0] wr_addr_i,
   input  logic [NWIRES-1:0] wr_data_i,
   input  logic [BIN_AW-1:0] rd_addr_i,
   output logic [NWIRES-1:0] rd_data_o
);

   logic [NWIRES-1:0] mem_q [0:RAM_DEPTH-1];
   logic [NWIRES-1:0] rd_data_q;

   // Write port plus write-first registered read port.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
         rd_data_q <= wr_data_i;
      end else begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/raw_hits_readout.sv
// Captures a window of delayed raw-hit frames on L1A and streams them out as
// a header word followed by NWORDS words per bin under valid/ready.
module raw_hits_readout
   import raw_hits_readout_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [NWIRES-1:0] frame_in,
   input  logic              l1a,
   input  logic [BIN_AW-1:0] nbins,
   output logic [WORD_W-1:0] daq_data,
   output logic              daq_valid,
   input  logic              daq_ready,
   output logic              daq_last,
   output logic              busy,
   output logic              l1a_lost
);

   state_t                 state_q;
   logic [BIN_AW-1:0]      n_q;
   logic [BIN_AW-1:0]      bin_q;
   logic [WORD_AW-1:0]     word_q;
   logic [L1A_CNT_W-1:0]   l1a_cnt_q;
   logic [WORD_W-1:0]      daq_data_q;
   logic                   daq_valid_q;
   logic                   daq_last_q;
   logic                   busy_q;
   logic                   l1a_lost_q;

   logic                   hs_c;
   logic                   load_c;
   logic                   wr_en_c;
   logic [BIN_AW-1:0]      wr_addr_c;
   logic [BIN_AW-1:0]      rd_addr_c;
   logic [NWIRES-1:0]      rd_frame;
   logic [BIN_AW-1:0]      nxt_bin_c;
   logic [WORD_AW-1:0]     nxt_word_c;
   logic [WORD_W-1:0]      word_c;
   logic                   word_last_c;
   logic [BIN_AW-1:0]      n_in_c;
   logic [L1A_CNT_W-1:0]   cnt_inc_c;

   // (bin_q, word_q) points at the next word to load into the output register.
   // The read address steps to the next bin in the same edge the pointer does,
   // so the RAM output already holds that bin when its first word is loaded.
   always_comb begin
      hs_c        = daq_valid_q && daq_ready;
      load_c      = hs_c && ((state_q == ST_HEADER) ||
                             ((state_q == ST_SEND) && !daq_last_q));
      n_in_c      = (nbins == '0) ? BIN_AW'(1) : nbins;
      cnt_inc_c   = l1a_cnt_q + L1A_CNT_W'(1);
      wr_en_c     = 1'b0;
      wr_addr_c   = bin_q;
      nxt_bin_c   = bin_q;
      nxt_word_c  = word_q + WORD_AW'(1);
      rd_addr_c   = '0;
      word_c      = rd_frame[WORD_W*word_q +: WORD_W];
      word_last_c = (bin_q == (n_q - BIN_AW'(1))) &&
                    (word_q == WORD_AW'(NWORDS - 1));

      if (word_q == WORD_AW'(NWORDS - 1)) begin
         nxt_word_c = '0;
         nxt_bin_c  = bin_q + BIN_AW'(1);
      end

      case (state_q)
         ST_IDLE: begin
            wr_en_c   = l1a;
            wr_addr_c = '0;
         end
         ST_CAPTURE: wr_en_c = 1'b1;
         ST_HEADER,
         ST_SEND:    rd_addr_c = load_c ? nxt_bin_c : bin_q;
         default:    wr_en_c = 1'b0;
      endcase
   end

   raw_frame_ram u_ram (
      .clk       (clk),
      .wr_en_i   (wr_en_c),
      .wr_addr_i (wr_addr_c),
      .wr_data_i (frame_in),
      .rd_addr_i (rd_addr_c),
      .rd_data_o (rd_frame)
   );

   // Control FSM with registered DAQ outputs, busy and lost-trigger flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         n_q         <= BIN_AW'(1);
         bin_q       <= '0;
         word_q      <= '0;
         l1a_cnt_q   <= '0;
         daq_data_q  <= '0;
         daq_valid_q <= 1'b0;
         daq_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         l1a_lost_q  <= 1'b0;
      end else begin
         l1a_lost_q <= l1a && (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (l1a) begin
                  l1a_cnt_q <= cnt_inc_c;
                  n_q       <= n_in_c;
                  busy_q    <= 1'b1;
                  if (n_in_c == BIN_AW'(1)) begin
                     state_q     <= ST_HEADER;
                     bin_q       <= '0;
                     word_q      <= '0;
                     daq_valid_q <= 1'b1;
                     daq_last_q  <= 1'b0;
                     daq_data_q  <= {HDR_MARK, cnt_inc_c};
                  end else begin
                     state_q <= ST_CAPTURE;
                     bin_q   <= BIN_AW'(1);
                  end
               end
            end
            ST_CAPTURE: begin
               if (bin_q == (n_q - BIN_AW'(1))) begin
                  state_q     <= ST_HEADER;
                  bin_q       <= '0;
                  word_q      <= '0;
                  daq_valid_q <= 1'b1;
                  daq_last_q  <= 1'b0;
                  daq_data_q  <= {HDR_MARK, l1a_cnt_q};
               end else begin
                  bin_q <= bin_q + BIN_AW'(1);
               end
            end
            ST_HEADER: begin
               if (hs_c) begin
                  state_q    <= ST_SEND;
                  daq_data_q <= word_c;
                  daq_last_q <= word_last_c;
                  bin_q      <= nxt_bin_c;
                  word_q     <= nxt_word_c;
               end
            end
            ST_SEND: begin
               if (hs_c) begin
                  if (daq_last_q) begin
                     state_q     <= ST_IDLE;
                     daq_valid_q <= 1'b0;
                     daq_last_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     bin_q       <= '0;
                     word_q      <= '0;
                  end else begin
                     daq_data_q <= word_c;
                     daq_last_q <= word_last_c;
                     bin_q      <= nxt_bin_c;
                     word_q     <= nxt_word_c;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign daq_data  = daq_data_q;
   assign daq_valid = daq_valid_q;
   assign daq_last  = daq_last_q;
   assign busy      = busy_q;
   assign l1a_lost  = l1a_lost_q;

endmodule

// File: doc/raw_hits_readout.md
Name: raw_hits_readout

Overview:
- Downstream consumer of the raw-hit delay pipeline.
- On an accepted L1A it captures a window of consecutive delayed 672-wire frames into an internal frame memory, then serializes them as a 16-bit DAQ word stream under a valid/ready handshake.
- Sits between the raw-hit delay output and the DAQ output multiplexer.

Parameters:
- NWIRES, 672, bits per raw-hit frame; must be a multiple of WORD_W.
- WORD_W, 16, DAQ word width.
- BIN_AW, 5, frame memory address width; the window holds at most 2^BIN_AW-1 = 31 bins.
- NWORDS, NWIRES/WORD_W (= 42), derived local constant; words per bin.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- frame_in  in  NWIRES  delayed raw-hit frame, one per clock.
- l1a  in  1  trigger request, single-cycle pulse.
- nbins  in  BIN_AW  window length in bins; sampled only when an L1A is accepted.
- daq_data  out  WORD_W  output word.
- daq_valid  out  1  daq_data is valid.
- daq_ready  in  1  sink accepts the word.
- daq_last  out  1  marks the final word of an event; qualified by daq_valid.
- busy  out  1  high whenever the block is not in IDLE.
- l1a_lost  out  1  one-cycle pulse when an L1A arrives while busy.

Behaviour:
- Reset, asynchronous:
  - daq_valid, daq_last, busy, l1a_lost = 0; daq_data = 0.
  - State = IDLE; bin/word counters = 0; l1a_cnt = 0.
  - Frame memory contents are don't-care.
  - Asserting rst mid-event aborts the event immediately; no partial event resumes after release.
- FSM states: IDLE, CAPTURE, HEADER, SEND.
- IDLE:
  - l1a=1 at edge t latches n = (nbins==0 ? 1 : nbins).
  - Writes frame_in sampled at edge t into mem[0]; increments l1a_cnt (12 bits, wraps 4095->0).
  - If n==1 -> HEADER, else -> CAPTURE with bin=1.
- CAPTURE:
  - Writes frame_in into mem[bin] each edge, bin++.
  - After writing bin n-1 -> HEADER.
  - Bins k=0..n-1 therefore hold the frames present at edges t..t+n-1.
- HEADER:
  - daq_valid=1, daq_data = {4'hD, l1a_cnt[11:0]} with the post-increment value, so the first event after reset reports 1.
  - First asserted in the cycle after the last capture edge.
  - On handshake -> SEND with bin=0, word=0.
- SEND:
  - Word (bin b, index w) = mem[b][WORD_W*w +: WORD_W], w = 0..NWORDS-1, b = 0..n-1, in that nesting order.
  - daq_last=1 only on (b=n-1, w=NWORDS-1).
  - Handshake on last word -> IDLE; busy falls on the following cycle.
- Handshake rules:
  - A word transfers on edges where daq_valid && daq_ready.
  - While daq_valid && !daq_ready, daq_data and daq_last must hold stable.
  - With daq_ready held high the stream has no bubbles: header plus n*NWORDS data words on consecutive cycles.
  - Memory read latency is hidden by prefetch/output register.
- Event size: exactly 1 + n*NWORDS words, e.g. n=4 -> 169 words.
- Busy: high from the cycle after L1A acceptance through the cycle of the final handshake.
- L1A outside IDLE (including the cycle of the last handshake):
  - Ignored; l1a_cnt unchanged.
  - l1a_lost pulses on the next cycle.
- frame_in and nbins are ignored outside the cases above.

Decomposition:
- Shared package holds:
  - Constants NWIRES=672, WORD_W=16, NWORDS=42.
  - Header marker 4'hD.
  - The FSM state enum.
- One natural sub-module: raw_frame_ram.
  - Simple dual-port, NWIRES wide, 2^BIN_AW deep.
  - Registered read; block RAM style.
  - The word mux and FSM stay in the top.

Test Plan:
- Reset, then l1a with nbins=1, frame_in[15:0]=16'h1234, other bits 0, daq_ready=1 -> header 16'hD001, then 42 words: word0=16'h1234, words1..41=0, daq_last on word 42 only, busy low after.
- nbins=3, frame_in = bin-index pattern (every 16-bit field = 16'h00k1 at capture edge k), ready=1 -> 127 consecutive valid words, bin order 0,1,2, no gaps.
- Same event with daq_ready toggling 1,0 every cycle -> identical 127-word sequence; data/last stable while stalled.
- l1a during SEND and on the final handshake cycle -> l1a_lost pulses twice; next accepted event header = 16'hD002.
- nbins=0 -> treated as 1: 43 words. nbins=31 -> 1303 words, last word = bin 30 word 41.
- rst asserted mid-SEND -> daq_valid/busy low same cycle; after release, a new l1a yields header 16'hD001 and a complete event.
